// File: rtl/lsu_wb_stage.sv
// Load/store unit and W-stage register: drives a valid/ready data bus with variable
// latency, stalls M while an access is outstanding, and extends load data into W.
module lsu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_alu_res,
  input  logic [DATA_W-1:0] m_rd2,
  input  logic [REG_AW-1:0] m_rt,
  input  logic              m_is_load,
  input  logic              m_is_store,
  input  logic [1:0]        m_size,
  input  logic              m_sign,
  input  logic              m_rf_we,
  input  logic [REG_AW-1:0] m_a3,
  output logic              stall_m,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [BE_W-1:0]   dbus_byteen,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_rsp_valid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              w_valid,
  output logic [ADDR_W-1:0] w_pc,
  output logic              w_rf_we,
  output logic [REG_AW-1:0] w_a3,
  output logic [DATA_W-1:0] w_wd,
  output logic [1:0]        w_exc
);

  localparam int OFF_W = $clog2(BE_W);
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e state;
  state_e state_next;

  logic [OFF_W-1:0]  off;
  logic              memop;
  logic              misaligned;
  logic              memop_aligned;
  logic              fwd_hit;
  logic [DATA_W-1:0] store_src;
  logic [DATA_W-1:0] store_shifted;
  logic [BE_W-1:0]   byteen_next;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] beat_addr;

  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [BE_W-1:0]   req_byteen;
  logic [DATA_W-1:0] req_wdata;

  logic [DATA_W-1:0] w_raw;
  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_size;
  logic              w_sign;
  logic              w_load;

  logic [DATA_W-1:0] load_shift;
  logic [DATA_W-1:0] ext_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;

  assign off           = m_alu_res[OFF_W-1:0];
  assign memop         = m_valid & (m_is_load | m_is_store);
  assign memop_aligned = memop & ~misaligned;
  assign eff_addr      = ADDR_W'(m_alu_res);
  assign beat_addr     = {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    misaligned = 1'b0;
    case (m_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off[1:0] != 2'b00);
      default: misaligned = (DATA_W < 64) ? 1'b1 : (off != '0);
    endcase
  end

  // Store data may depend on the instruction currently in W.
  always_comb begin
    fwd_hit       = w_rf_we & (w_a3 != '0) & (w_a3 == m_rt);
    store_src     = fwd_hit ? w_wd : m_rd2;
    store_shifted = store_src << {off, 3'b000};
  end

  always_comb begin
    byteen_next = '1;
    case (m_size)
      2'd0:    byteen_next = BE_W'(1) << off;
      2'd1:    byteen_next = BE_W'(3) << off;
      2'd2:    byteen_next = BE_W'(15) << off;
      default: byteen_next = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (memop_aligned)  state_next = REQ;
      REQ:     if (dbus_req_ready) state_next = WAIT;
      WAIT:    if (dbus_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dbus_req_valid = (state == REQ);
    stall_m        = memop_aligned & ~((state == WAIT) & dbus_rsp_valid);
  end

  // The forwarded value is frozen here: W turns into a bubble while M is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_byteen <= '0;
      req_wdata  <= '0;
    end else if ((state == IDLE) && memop_aligned) begin
      req_addr   <= beat_addr;
      req_we     <= m_is_store & ~m_is_load;
      req_byteen <= byteen_next;
      req_wdata  <= store_shifted;
    end
  end

  assign dbus_addr   = req_addr;
  assign dbus_we     = req_we;
  assign dbus_byteen = req_byteen;
  assign dbus_wdata  = req_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_pc    <= '0;
      w_rf_we <= 1'b0;
      w_a3    <= '0;
      w_exc   <= EXC_NONE;
      w_raw   <= '0;
      w_off   <= '0;
      w_size  <= 2'd0;
      w_sign  <= 1'b0;
      w_load  <= 1'b0;
    end else if (stall_m) begin
      w_valid <= 1'b0;
      w_rf_we <= 1'b0;
      w_exc   <= EXC_NONE;
    end else begin
      w_valid <= m_valid;
      w_pc    <= m_pc;
      w_rf_we <= m_valid & m_rf_we & ~(memop & misaligned);
      w_a3    <= m_a3;
      if (memop & misaligned) begin
        w_exc <= m_is_load ? EXC_ADEL : EXC_ADES;
      end else begin
        w_exc <= EXC_NONE;
      end
      w_raw  <= (memop_aligned & m_is_load) ? dbus_rdata : m_alu_res;
      w_off  <= off;
      w_size <= m_size;
      w_sign <= m_sign;
      w_load <= memop_aligned & m_is_load;
    end
  end

  // Extension works on a lane-aligned copy of the beat, masking to the access width.
  always_comb begin
    load_shift = w_raw >> {w_off, 3'b000};
    ext_mask   = '0;
    sign_bit   = 1'b0;
    case (w_size)
      2'd0: begin
        ext_mask[7:0] = '1;
        sign_bit      = load_shift[7];
      end
      2'd1: begin
        ext_mask[15:0] = '1;
        sign_bit       = load_shift[15];
      end
      2'd2: begin
        ext_mask[31:0] = '1;
        sign_bit       = load_shift[31];
      end
      default: begin
        ext_mask = '1;
        sign_bit = 1'b0;
      end
    endcase
    load_ext = (load_shift & ext_mask) | ((w_sign & sign_bit) ? ~ext_mask : '0);
    w_wd     = w_load ? load_ext : w_raw;
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Bench for lsu_wb_stage: directed vector table, reset/abandon sequence, 64-bit
// instance checks and randomized ops against a behavioural model.
module tb_lsu_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        m_valid, m_is_load, m_is_store, m_sign, m_rf_we;
  logic [31:0] m_pc, m_alu_res, m_rd2;
  logic [4:0]  m_rt, m_a3;
  logic [1:0]  m_size;
  logic        stall_m, dbus_req_valid, dbus_req_ready, dbus_we, dbus_rsp_valid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_byteen;
  logic        w_valid, w_rf_we;
  logic [31:0] w_pc, w_wd;
  logic [4:0]  w_a3;
  logic [1:0]  w_exc;

  logic        m_valid_d, m_is_load_d, m_is_store_d, m_sign_d, m_rf_we_d;
  logic [31:0] m_pc_d;
  logic [63:0] m_alu_res_d, m_rd2_d;
  logic [4:0]  m_rt_d, m_a3_d;
  logic [1:0]  m_size_d;
  logic        stall_m_d, dbus_req_valid_d, dbus_req_ready_d, dbus_we_d, dbus_rsp_valid_d;
  logic [31:0] dbus_addr_d;
  logic [63:0] dbus_wdata_d, dbus_rdata_d;
  logic [7:0]  dbus_byteen_d;
  logic        w_valid_d, w_rf_we_d;
  logic [31:0] w_pc_d;
  logic [63:0] w_wd_d;
  logic [4:0]  w_a3_d;
  logic [1:0]  w_exc_d;

  lsu_wb_stage dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_alu_res(m_alu_res),
    .m_rd2(m_rd2), .m_rt(m_rt), .m_is_load(m_is_load), .m_is_store(m_is_store),
    .m_size(m_size), .m_sign(m_sign), .m_rf_we(m_rf_we), .m_a3(m_a3), .stall_m(stall_m),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_byteen(dbus_byteen), .dbus_wdata(dbus_wdata),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata), .w_valid(w_valid),
    .w_pc(w_pc), .w_rf_we(w_rf_we), .w_a3(w_a3), .w_wd(w_wd), .w_exc(w_exc)
  );

  lsu_wb_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .m_valid(m_valid_d), .m_pc(m_pc_d), .m_alu_res(m_alu_res_d),
    .m_rd2(m_rd2_d), .m_rt(m_rt_d), .m_is_load(m_is_load_d), .m_is_store(m_is_store_d),
    .m_size(m_size_d), .m_sign(m_sign_d), .m_rf_we(m_rf_we_d), .m_a3(m_a3_d),
    .stall_m(stall_m_d), .dbus_req_valid(dbus_req_valid_d),
    .dbus_req_ready(dbus_req_ready_d), .dbus_we(dbus_we_d), .dbus_addr(dbus_addr_d),
    .dbus_byteen(dbus_byteen_d), .dbus_wdata(dbus_wdata_d),
    .dbus_rsp_valid(dbus_rsp_valid_d), .dbus_rdata(dbus_rdata_d), .w_valid(w_valid_d),
    .w_pc(w_pc_d), .w_rf_we(w_rf_we_d), .w_a3(w_a3_d), .w_wd(w_wd_d), .w_exc(w_exc_d)
  );

  typedef struct {
    logic        is_load, is_store, sign, rf_we, early_rsp, stray_rsp;
    logic [1:0]  size;
    logic [4:0]  a3, rt;
    logic [31:0] addr, rd2, rdata;
    int          rd_dly, rsp_dly;
    logic [31:0] e_addr, e_wdata, e_wd;
    logic [3:0]  e_be;
    logic [1:0]  e_exc;
    logic        e_rf_we;
  } vec_t;

  int tests = 0;
  int failed = 0;
  logic [31:0] pc;
  logic        mdl_we;
  logic [4:0]  mdl_a3;
  logic [31:0] mdl_wd;
  vec_t        tbl[15];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t op(input logic ld, input logic st, input logic [1:0] size,
                              input logic sign, input logic rf_we, input logic [4:0] a3,
                              input logic [4:0] rt, input logic [31:0] addr,
                              input logic [31:0] rd2, input logic [31:0] rdata,
                              input int rd_dly, input int rsp_dly);
    vec_t v;
    v.is_load = ld;  v.is_store = st; v.size = size; v.sign = sign; v.rf_we = rf_we;
    v.a3 = a3; v.rt = rt; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
    v.rd_dly = rd_dly; v.rsp_dly = rsp_dly; v.early_rsp = 1'b0; v.stray_rsp = 1'b0;
    v.e_addr = '0; v.e_wdata = '0; v.e_be = '0; v.e_wd = '0; v.e_exc = '0; v.e_rf_we = 1'b0;
    return v;
  endfunction

  function automatic vec_t exp_bus(input vec_t vin, input logic [31:0] a,
                                   input logic [3:0] be, input logic [31:0] wdata);
    vec_t v = vin;
    v.e_addr = a; v.e_be = be; v.e_wdata = wdata;
    return v;
  endfunction

  function automatic vec_t exp_w(input vec_t vin, input logic [31:0] wd,
                                 input logic [1:0] exc, input logic rf_we);
    vec_t v = vin;
    v.e_wd = wd; v.e_exc = exc; v.e_rf_we = rf_we;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic on a 32-bit beat, forwarding from the last result.
  function automatic vec_t model(input vec_t vin);
    vec_t v = vin;
    int off, nbytes;
    logic [63:0] src, val, mask;
    bit mem, mis;
    mem = v.is_load || v.is_store;
    off = int'(v.addr % 4);
    mis = mem && ((v.size == 1 && off % 2 != 0) || (v.size == 2 && off != 0) || v.size == 3);
    v.e_exc = !mis ? 2'd0 : (v.is_load ? 2'd1 : 2'd2);
    v.e_rf_we = v.rf_we && !mis;
    nbytes = 1 << v.size;
    v.e_addr = v.addr - 32'(off);
    v.e_be = 4'(((1 << nbytes) - 1) << off);
    src = (mdl_we && mdl_a3 != 0 && mdl_a3 == v.rt) ? 64'(mdl_wd) : 64'(v.rd2);
    v.e_wdata = 32'(src << (8 * off));
    if (v.is_load && !mis) begin
      val  = 64'(v.rdata) >> (8 * off);
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = val & mask;
      if (v.sign && val[8 * nbytes - 1]) val = val | ~mask;
      v.e_wd = val[31:0];
    end else begin
      v.e_wd = v.addr;
    end
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    int stall_cnt = 0;
    m_valid = 1'b1; m_pc = pc; m_alu_res = v.addr; m_rd2 = v.rd2; m_rt = v.rt;
    m_is_load = v.is_load; m_is_store = v.is_store; m_size = v.size; m_sign = v.sign;
    m_rf_we = v.rf_we; m_a3 = v.a3;
    if ((v.is_load || v.is_store) && v.e_exc == 2'd0) begin
      dbus_rsp_valid = v.stray_rsp; dbus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check_output("idle_req_valid", 64'(dbus_req_valid), 64'd0);
      if (stall_m) stall_cnt++;
      @(posedge clk); #1;
      for (int i = 0; i <= v.rd_dly; i++) begin
        dbus_req_ready = (i == v.rd_dly);
        dbus_rsp_valid = v.early_rsp && (i == v.rd_dly);
        @(negedge clk);
        check_output("req_valid", 64'(dbus_req_valid), 64'd1);
        check_output("req_addr", 64'(dbus_addr), 64'(v.e_addr));
        check_output("req_byteen", 64'(dbus_byteen), 64'(v.e_be));
        check_output("req_wdata", 64'(dbus_wdata), 64'(v.e_wdata));
        check_output("req_we", 64'(dbus_we), 64'(v.is_store));
        if (stall_m) stall_cnt++;
        @(posedge clk); #1;
      end
      dbus_req_ready = 1'b0;
      for (int i = 1; i <= v.rsp_dly; i++) begin
        dbus_rsp_valid = (i == v.rsp_dly);
        dbus_rdata = (i == v.rsp_dly) ? v.rdata : 32'hBAD0_BAD0;
        @(negedge clk);
        check_output("wait_req_valid", 64'(dbus_req_valid), 64'd0);
        if (stall_m) stall_cnt++;
        @(posedge clk); #1;
      end
      dbus_rsp_valid = 1'b0;
      check_output("stall_cycles", 64'(stall_cnt), 64'(v.rd_dly + v.rsp_dly + 1));
    end else begin
      @(negedge clk);
      check_output("nomem_req_valid", 64'(dbus_req_valid), 64'd0);
      if (stall_m) stall_cnt++;
      @(posedge clk); #1;
      check_output("stall_cycles", 64'(stall_cnt), 64'd0);
    end
    m_valid = 1'b0;
    check_output("w_valid", 64'(w_valid), 64'd1);
    check_output("w_pc", 64'(w_pc), 64'(pc));
    check_output("w_a3", 64'(w_a3), 64'(v.a3));
    check_output("w_exc", 64'(w_exc), 64'(v.e_exc));
    check_output("w_rf_we", 64'(w_rf_we), 64'(v.e_rf_we));
    if (v.e_exc == 2'd0) check_output("w_wd", 64'(w_wd), 64'(v.e_wd));
    mdl_we = v.e_rf_we; mdl_a3 = v.a3; mdl_wd = v.e_wd;
    pc = pc + 32'd4;
  endtask

  task automatic run_d(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                       input logic [63:0] rdata, input logic [7:0] e_be,
                       input logic [63:0] e_wd, input logic [1:0] e_exc);
    m_valid_d = 1'b1; m_is_load_d = 1'b1; m_alu_res_d = 64'(addr); m_size_d = size;
    m_sign_d = sign; m_rf_we_d = 1'b1; m_a3_d = 5'd1;
    if (e_exc == 2'd0) begin
      @(negedge clk);
      check_output("d_idle_stall", 64'(stall_m_d), 64'd1);
      @(posedge clk); #1;
      dbus_req_ready_d = 1'b1;
      @(negedge clk);
      check_output("d_req_valid", 64'(dbus_req_valid_d), 64'd1);
      check_output("d_req_addr", 64'(dbus_addr_d), 64'(addr & 32'hFFFF_FFF8));
      check_output("d_req_byteen", 64'(dbus_byteen_d), 64'(e_be));
      @(posedge clk); #1;
      dbus_req_ready_d = 1'b0; dbus_rsp_valid_d = 1'b1; dbus_rdata_d = rdata;
      @(negedge clk);
      check_output("d_rsp_stall", 64'(stall_m_d), 64'd0);
      @(posedge clk); #1;
      dbus_rsp_valid_d = 1'b0;
    end else begin
      @(negedge clk);
      check_output("d_mis_req_valid", 64'(dbus_req_valid_d), 64'd0);
      @(posedge clk); #1;
    end
    m_valid_d = 1'b0;
    check_output("d_w_exc", 64'(w_exc_d), 64'(e_exc));
    if (e_exc == 2'd0) check_output("d_w_wd", w_wd_d, e_wd);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    m_valid = 0; m_pc = 0; m_alu_res = 0; m_rd2 = 0; m_rt = 0; m_is_load = 0; m_is_store = 0;
    m_size = 0; m_sign = 0; m_rf_we = 0; m_a3 = 0;
    dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rdata = 0;
    m_valid_d = 0; m_pc_d = 0; m_alu_res_d = 0; m_rd2_d = 0; m_rt_d = 0; m_is_load_d = 0;
    m_is_store_d = 0; m_size_d = 0; m_sign_d = 0; m_rf_we_d = 0; m_a3_d = 0;
    dbus_req_ready_d = 0; dbus_rsp_valid_d = 0; dbus_rdata_d = 0;
    pc = 32'h400; mdl_we = 0; mdl_a3 = 0; mdl_wd = 0;

    tbl[0]  = exp_w(op(0,0,2'd0,0,1,5'd8,5'd0,32'h1234,0,0,0,0), 32'h1234, 2'd0, 1);
    tbl[1]  = exp_w(exp_bus(op(1,0,2'd0,1,1,5'd5,5'd0,32'h1003,0,32'h80FF_FF12,0,2),
                            32'h1000, 4'b1000, 0), 32'hFFFF_FF80, 2'd0, 1);
    tbl[2]  = exp_w(op(0,0,2'd0,0,1,5'd9,5'd0,32'hAAAA_BEEF,0,0,0,0), 32'hAAAA_BEEF, 2'd0, 1);
    tbl[3]  = exp_w(exp_bus(op(0,1,2'd1,0,0,5'd0,5'd9,32'h2002,32'h1234_5678,0,3,1),
                            32'h2000, 4'b1100, 32'hBEEF_0000), 32'h2002, 2'd0, 0);
    tbl[4]  = exp_w(op(1,0,2'd2,0,1,5'd4,5'd0,32'h3001,0,0,0,0), 0, 2'd1, 0);
    tbl[5]  = exp_w(op(0,1,2'd2,0,0,5'd0,5'd0,32'h3002,0,0,0,0), 0, 2'd2, 0);
    tbl[6]  = exp_w(exp_bus(op(1,0,2'd1,0,1,5'd6,5'd0,32'h4002,0,32'h8001_7FFF,1,1),
                            32'h4000, 4'b1100, 0), 32'h0000_8001, 2'd0, 1);
    tbl[6].early_rsp = 1'b1;
    tbl[7]  = exp_w(exp_bus(op(1,0,2'd1,1,1,5'd7,5'd0,32'h4006,0,32'h8001_7FFF,0,1),
                            32'h4004, 4'b1100, 0), 32'hFFFF_8001, 2'd0, 1);
    tbl[8]  = exp_w(exp_bus(op(1,0,2'd2,0,1,5'd6,5'd0,32'h5000,0,32'hDEAD_BEEF,2,3),
                            32'h5000, 4'b1111, 0), 32'hDEAD_BEEF, 2'd0, 1);
    tbl[9]  = exp_w(exp_bus(op(0,1,2'd0,0,0,5'd0,5'd6,32'h6001,32'h77,0,0,1),
                            32'h6000, 4'b0010, 32'hADBE_EF00), 32'h6001, 2'd0, 0);
    tbl[10] = exp_w(op(0,0,2'd0,0,1,5'd0,5'd0,32'h5555_5555,0,0,0,0), 32'h5555_5555, 2'd0, 1);
    tbl[11] = exp_w(exp_bus(op(0,1,2'd2,0,0,5'd0,5'd0,32'h7000,32'hCAFE_F00D,0,0,1),
                            32'h7000, 4'b1111, 32'hCAFE_F00D), 32'h7000, 2'd0, 0);
    tbl[12] = exp_w(op(1,0,2'd3,0,1,5'd3,5'd0,32'h8000,0,0,0,0), 0, 2'd1, 0);
    tbl[13] = exp_w(exp_bus(op(1,0,2'd0,0,1,5'd2,5'd0,32'h9002,0,32'h00AB_0000,1,2),
                            32'h9000, 4'b0100, 0), 32'h0000_00AB, 2'd0, 1);
    tbl[14] = exp_w(exp_bus(op(0,1,2'd0,0,0,5'd0,5'd3,32'hA003,32'hC3,0,0,1),
                            32'hA000, 4'b1000, 32'hC300_0000), 32'hA003, 2'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_w_valid", 64'(w_valid), 64'd0);
    check_output("rst_w_pc", 64'(w_pc), 64'd0);
    check_output("rst_w_rf_we", 64'(w_rf_we), 64'd0);
    check_output("rst_w_a3", 64'(w_a3), 64'd0);
    check_output("rst_w_wd", 64'(w_wd), 64'd0);
    check_output("rst_w_exc", 64'(w_exc), 64'd0);
    check_output("rst_req_valid", 64'(dbus_req_valid), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) apply_stimulus(tbl[i]);

    // Abandon a load in WAIT, then feed a stray response into the next op's IDLE cycle.
    m_valid = 1; m_pc = pc; m_alu_res = 32'h100; m_is_load = 1; m_is_store = 0;
    m_size = 2'd2; m_sign = 0; m_rf_we = 1; m_a3 = 5'd1; m_rt = 5'd0;
    @(posedge clk); #1;
    dbus_req_ready = 1'b1;
    @(negedge clk);
    check_output("abandon_req_valid", 64'(dbus_req_valid), 64'd1);
    @(posedge clk); #1;
    dbus_req_ready = 1'b0;
    @(negedge clk);
    check_output("abandon_wait_stall", 64'(stall_m), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1; m_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("abandon_w_valid", 64'(w_valid), 64'd0);
    check_output("abandon_w_wd", 64'(w_wd), 64'd0);
    check_output("abandon_w_pc", 64'(w_pc), 64'd0);
    check_output("abandon_req_idle", 64'(dbus_req_valid), 64'd0);
    mdl_we = 0;
    v = exp_w(exp_bus(op(1,0,2'd2,0,1,5'd2,5'd0,32'h104,0,32'h1122_3344,0,1),
                      32'h104, 4'b1111, 0), 32'h1122_3344, 2'd0, 1);
    v.stray_rsp = 1'b1;
    apply_stimulus(v);

    run_d(32'h40, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 2'd0);
    run_d(32'h46, 2'd1, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hC0, 64'h0000_0000_0000_0123, 2'd0);
    run_d(32'h44, 2'd2, 1'b1, 64'h89AB_CDEF_1234_5678, 8'hF0, 64'hFFFF_FFFF_89AB_CDEF, 2'd0);
    run_d(32'h44, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 2'd1);

    for (int k = 0; k < 40; k++) begin
      int kind;
      v = op(0,0,2'd0,0,0,5'd0,5'd0,0,0,0,0,1);
      kind = int'($urandom_range(0, 2));
      v.is_load = (kind == 1);
      v.is_store = (kind == 2);
      v.size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      v.addr = $urandom;
      if ($urandom_range(0, 2) != 0 && v.size != 2'd3)
        v.addr = v.addr & ~(32'(1 << v.size) - 32'd1);
      v.sign = 1'($urandom_range(0, 1));
      v.a3 = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.rf_we = v.is_store ? 1'b0 : ($urandom_range(0, 4) != 0);
      v.rd2 = $urandom;
      v.rdata = $urandom;
      v.rd_dly = int'($urandom_range(0, 3));
      v.rsp_dly = int'($urandom_range(1, 3));
      v.early_rsp = 1'($urandom_range(0, 1));
      v.stray_rsp = 1'($urandom_range(0, 1));
      apply_stimulus(model(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
